serial_io_port: RTL and testbench

//  Device-side end of the processor's serial IO interface (serial_in/valid/ready <-> serial_out/rden/wren).

---
 rtl/serial_io_port.sv | 163 ++++++++++++++++
 tb/tb_serial_io_port.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_port.sv
// serial_io_port: device-side end of the processor serial IO interface.
// Two byte FIFOs: RX carries host bytes toward the processor, TX carries
// processor writes toward the host. Sticky error flags record misuse of
// either handshake until the next reset.

// Show-ahead circular byte FIFO with registered storage and occupancy count.
module serial_io_fifo #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  push_req,
   input  logic                  pop_req,
   output logic [7:0]            head_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem_q [DEPTH];
   logic [7:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  push;
   logic                  pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_COUNT);
   assign count     = count_q;
   assign head_data = empty ? 8'h00 : mem_q[rd_ptr_q];

   // Full/empty gate the requests using the pre-edge state, so a push into a
   // full FIFO is refused even when a pop happens on the same edge.
   assign push = push_req && !full;
   assign pop  = pop_req && !empty;

   // Next pointers, count and storage; pointer width makes the wrap natural.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every buffered byte.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_q    <= '{default: 8'h00};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// Top level: wires the two FIFOs to the processor and host handshakes.
module serial_io_port #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [7:0]            serial_in,
   output logic                  serial_valid_in,
   output logic                  serial_ready_in,
   input  logic [7:0]            serial_out,
   input  logic                  serial_rden_out,
   input  logic                  serial_wren_out,
   input  logic [7:0]            host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [7:0]            host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready,
   output logic                  rx_overflow,
   output logic                  rx_underflow,
   output logic                  tx_overflow,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic [DEPTH_LOG2:0]   tx_count
);

   logic rx_full, rx_empty;
   logic tx_full, tx_empty;
   logic rx_overflow_q, rx_overflow_d;
   logic rx_underflow_q, rx_underflow_d;
   logic tx_overflow_q, tx_overflow_d;

   serial_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_data   (host_rx_data),
      .push_req  (host_rx_valid),
      .pop_req   (serial_rden_out),
      .head_data (serial_in),
      .count     (rx_count),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   serial_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .wr_data   (serial_out),
      .push_req  (serial_wren_out),
      .pop_req   (host_tx_ready),
      .head_data (host_tx_data),
      .count     (tx_count),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   assign serial_valid_in = !rx_empty;
   assign host_rx_ready   = !rx_full;
   assign host_tx_valid   = !tx_empty;
   assign serial_ready_in = !tx_full;

   assign rx_overflow  = rx_overflow_q;
   assign rx_underflow = rx_underflow_q;
   assign tx_overflow  = tx_overflow_q;

   // Sticky error flags: once a refused transfer is seen they stay set.
   always_comb begin
      rx_overflow_d  = rx_overflow_q  | (host_rx_valid   & rx_full);
      rx_underflow_d = rx_underflow_q | (serial_rden_out & rx_empty);
      tx_overflow_d  = tx_overflow_q  | (serial_wren_out & tx_full);
   end

   // Flag registers, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_overflow_q  <= 1'b0;
         rx_underflow_q <= 1'b0;
         tx_overflow_q  <= 1'b0;
      end else begin
         rx_overflow_q  <= rx_overflow_d;
         rx_underflow_q <= rx_underflow_d;
         tx_overflow_q  <= tx_overflow_d;
      end
   end

endmodule

// File: tb/tb_serial_io_port.sv
// Testbench for serial_io_port: directed scenarios with a byte scoreboard.
// Stimulus pushes expected bytes into per-direction queues; a monitor pops
// and compares whenever the DUT hands a byte across either interface.
module tb_serial_io_port;

   logic       clock;
   logic       reset;
   logic [7:0] serial_in;
   logic       serial_valid_in;
   logic       serial_ready_in;
   logic [7:0] serial_out;
   logic       serial_rden_out;
   logic       serial_wren_out;
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;
   logic       rx_overflow;
   logic       rx_underflow;
   logic       tx_overflow;
   logic [3:0] rx_count;
   logic [3:0] tx_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];

   serial_io_port #(.DEPTH_LOG2(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .serial_in       (serial_in),
      .serial_valid_in (serial_valid_in),
      .serial_ready_in (serial_ready_in),
      .serial_out      (serial_out),
      .serial_rden_out (serial_rden_out),
      .serial_wren_out (serial_wren_out),
      .host_rx_data    (host_rx_data),
      .host_rx_valid   (host_rx_valid),
      .host_rx_ready   (host_rx_ready),
      .host_tx_data    (host_tx_data),
      .host_tx_valid   (host_tx_valid),
      .host_tx_ready   (host_tx_ready),
      .rx_overflow     (rx_overflow),
      .rx_underflow    (rx_underflow),
      .tx_overflow     (tx_overflow),
      .rx_count        (rx_count),
      .tx_count        (tx_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard time limit so a stuck run still reports.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every byte crossing toward processor or host is scoreboarded.
   always @(negedge clock) begin
      if (reset && serial_rden_out && serial_valid_in) begin
         total++;
         if (rx_exp.size() == 0) begin
            bad++;
            $display("[TB] FAIL rx_unexpected: actual=0x%0h required=none", serial_in);
         end else begin
            logic [7:0] e;
            e = rx_exp.pop_front();
            if (serial_in !== e) begin
               bad++;
               $display("[TB] FAIL rx_byte: actual=0x%0h required=0x%0h", serial_in, e);
            end
         end
      end
      if (reset && host_tx_ready && host_tx_valid) begin
         total++;
         if (tx_exp.size() == 0) begin
            bad++;
            $display("[TB] FAIL tx_unexpected: actual=0x%0h required=none", host_tx_data);
         end else begin
            logic [7:0] e;
            e = tx_exp.pop_front();
            if (host_tx_data !== e) begin
               bad++;
               $display("[TB] FAIL tx_byte: actual=0x%0h required=0x%0h", host_tx_data, e);
            end
         end
      end
   end

   // One clock: edge happens with current inputs, then settle 1 time unit.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic host_push(input logic [7:0] b, input bit expect_accept);
      host_rx_data  = b;
      host_rx_valid = 1'b1;
      if (expect_accept) rx_exp.push_back(b);
      tick();
      host_rx_valid = 1'b0;
   endtask

   task automatic proc_read();
      serial_rden_out = 1'b1;
      tick();
      serial_rden_out = 1'b0;
   endtask

   task automatic proc_write(input logic [7:0] b, input bit expect_accept);
      serial_out      = b;
      serial_wren_out = 1'b1;
      if (expect_accept) tx_exp.push_back(b);
      tick();
      serial_wren_out = 1'b0;
   endtask

   task automatic apply_stimulus();
      // Reset state
      reset = 1'b0;
      serial_out = 8'h00; serial_rden_out = 1'b0; serial_wren_out = 1'b0;
      host_rx_data = 8'h00; host_rx_valid = 1'b0; host_tx_ready = 1'b0;
      #12;
      reset = 1'b1;
      tick();
      check_output("rst_valid_in", serial_valid_in, 0);
      check_output("rst_ready_in", serial_ready_in, 1);
      check_output("rst_host_rx_ready", host_rx_ready, 1);
      check_output("rst_host_tx_valid", host_tx_valid, 0);
      check_output("rst_serial_in", serial_in, 8'h00);
      check_output("rst_host_tx_data", host_tx_data, 8'h00);

      // Scenario 1: three bytes host -> processor
      $display("[TB] scenario 1: rx basic");
      host_push(8'h41, 1'b1);
      check_output("s1_valid_after_push", serial_valid_in, 1);
      check_output("s1_head", serial_in, 8'h41);
      host_push(8'h42, 1'b1);
      host_push(8'h43, 1'b1);
      check_output("s1_count3", rx_count, 3);
      for (int i = 0; i < 3; i++) proc_read();
      check_output("s1_valid_end", serial_valid_in, 0);
      check_output("s1_count_end", rx_count, 0);

      // Scenario 2: RX overflow after 8 bytes
      $display("[TB] scenario 2: rx overflow");
      for (int i = 0; i < 8; i++) host_push(8'h60 + 8'(i), 1'b1);
      check_output("s2_ready_full", host_rx_ready, 0);
      check_output("s2_count_full", rx_count, 8);
      check_output("s2_ovf_before", rx_overflow, 0);
      host_push(8'h68, 1'b0);
      check_output("s2_ovf_after", rx_overflow, 1);
      check_output("s2_count_still", rx_count, 8);
      for (int i = 0; i < 8; i++) proc_read();
      check_output("s2_drained", rx_count, 0);
      check_output("s2_ovf_sticky", rx_overflow, 1);

      // Scenario 3: TX byte held until host ready
      $display("[TB] scenario 3: tx hold");
      proc_write(8'h55, 1'b1);
      check_output("s3_valid", host_tx_valid, 1);
      check_output("s3_data", host_tx_data, 8'h55);
      tick(); tick();
      check_output("s3_data_held", host_tx_data, 8'h55);
      host_tx_ready = 1'b1;
      tick();
      host_tx_ready = 1'b0;
      check_output("s3_count0", tx_count, 0);
      check_output("s3_valid0", host_tx_valid, 0);

      // Scenario 4: TX full, overflow write alongside a pop
      $display("[TB] scenario 4: tx overflow with pop");
      for (int i = 0; i < 8; i++) proc_write(8'h10 + 8'(i), 1'b1);
      check_output("s4_ready_full", serial_ready_in, 0);
      check_output("s4_count8", tx_count, 8);
      check_output("s4_ovf_before", tx_overflow, 0);
      serial_out = 8'h99; serial_wren_out = 1'b1; host_tx_ready = 1'b1;
      tick();
      serial_wren_out = 1'b0; host_tx_ready = 1'b0;
      check_output("s4_ovf_after", tx_overflow, 1);
      check_output("s4_count7", tx_count, 7);
      check_output("s4_head", host_tx_data, 8'h11);
      host_tx_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      host_tx_ready = 1'b0;
      check_output("s4_drained", tx_count, 0);

      // Scenario 5: read while RX empty
      $display("[TB] scenario 5: rx underflow");
      check_output("s5_unf_before", rx_underflow, 0);
      proc_read();
      check_output("s5_unf_after", rx_underflow, 1);
      check_output("s5_serial_in", serial_in, 8'h00);
      check_output("s5_count", rx_count, 0);
      host_push(8'h5A, 1'b1);
      proc_read();
      check_output("s5_count_after", rx_count, 0);

      // Scenario 6: asynchronous reset mid-stream
      $display("[TB] scenario 6: async reset");
      for (int i = 0; i < 4; i++) host_push(8'hA0 + 8'(i), 1'b1);
      for (int i = 0; i < 4; i++) proc_write(8'hB0 + 8'(i), 1'b1);
      check_output("s6_rx4", rx_count, 4);
      check_output("s6_tx4", tx_count, 4);
      #2;
      reset = 1'b0;
      rx_exp.delete();
      tx_exp.delete();
      #1;
      check_output("s6_rx0", rx_count, 0);
      check_output("s6_tx0", tx_count, 0);
      check_output("s6_rx_ovf", rx_overflow, 0);
      check_output("s6_rx_unf", rx_underflow, 0);
      check_output("s6_tx_ovf", tx_overflow, 0);
      check_output("s6_ready_in", serial_ready_in, 1);
      check_output("s6_host_rx_ready", host_rx_ready, 1);
      check_output("s6_valid_in", serial_valid_in, 0);
      check_output("s6_tx_valid", host_tx_valid, 0);
      tick();
      reset = 1'b1;
      tick();
      host_push(8'h77, 1'b1);
      proc_write(8'h88, 1'b1);
      check_output("s6_post_head", serial_in, 8'h77);
      proc_read();
      host_tx_ready = 1'b1;
      tick();
      host_tx_ready = 1'b0;
      check_output("s6_post_rx", rx_count, 0);
      check_output("s6_post_tx", tx_count, 0);
   endtask

   initial begin
      apply_stimulus();
      tick();
      check_output("rx_scoreboard_empty", rx_exp.size(), 0);
      check_output("tx_scoreboard_empty", tx_exp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
